// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: tracks in-flight GPR writers in a tag pipeline, picks
// forwarding sources for rs/rt and raises stall on not-yet-ready and HI/LO hazards.
module hazard_scoreboard #(
  parameter  int RW     = 5,
  parameter  int STAGES = 3,
  parameter  int MD_LAT = 32,
  parameter  int CNT_W  = 16,
  localparam int SW     = $clog2(STAGES + 1),
  localparam int MW     = $clog2(MD_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs,
  input  logic             id_rs_used,
  input  logic [RW-1:0]    id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [RW-1:0]    id_rd,
  input  logic [SW-1:0]    id_ready_stg,
  input  logic             id_md_start,
  input  logic             id_hilo_rd,
  input  logic             flush,
  output logic [SW-1:0]    fwd_sel_a,
  output logic [SW-1:0]    fwd_sel_b,
  output logic             stall,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // Index k holds tracked position k+1 (index 0 = EX).
  logic [STAGES-1:0]         vld_q, vld_d;
  logic [STAGES-1:0][RW-1:0] rd_q, rd_d;
  logic [STAGES-1:0][SW-1:0] rdy_q, rdy_d;
  logic [MW-1:0]             md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]          stall_cycles_q, stall_cycles_d;

  logic [SW:0]   res_a, res_b;
  logic [SW-1:0] sel_a, sel_b;
  logic          req_a, req_b, hilo_haz, stall_int, accept;

  // Returns {stall_request, fwd_sel}; scanning oldest to youngest lets the
  // youngest match overwrite any older one, so older entries never leak through.
  function automatic logic [SW:0] resolve(
    input logic                      rd_use,
    input logic [RW-1:0]             src,
    input logic [STAGES-1:0]         vld,
    input logic [STAGES-1:0][RW-1:0] rd,
    input logic [STAGES-1:0][SW-1:0] rdy
  );
    logic [SW:0] res;
    res = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (rd_use && (src != '0) && vld[k] && (rd[k] == src)) begin
        if (k + 1 >= int'(rdy[k])) res = {1'b0, SW'(k + 1)};
        else                       res = {1'b1, {SW{1'b0}}};
      end
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    res_a     = resolve(id_valid & id_rs_used, id_rs, vld_q, rd_q, rdy_q);
    res_b     = resolve(id_valid & id_rt_used, id_rt, vld_q, rd_q, rdy_q);
    req_a     = res_a[SW];
    req_b     = res_b[SW];
    sel_a     = res_a[SW-1:0];
    sel_b     = res_b[SW-1:0];
    hilo_haz  = id_valid & (id_hilo_rd | id_md_start) & (md_cnt_q != '0);
    stall_int = ~rst & ~flush & (req_a | req_b | hilo_haz);
    accept    = id_valid & ~stall_int & ~flush;

    vld_d    = '0;
    rd_d     = '0;
    rdy_d    = '0;
    vld_d[0] = accept & id_wr_en & (id_rd != '0);
    rd_d[0]  = id_rd;
    rdy_d[0] = id_ready_stg;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      rdy_d[k] = rdy_q[k-1];
    end

    md_cnt_d = md_cnt_q;
    if (accept && id_md_start) md_cnt_d = MW'(MD_LAT);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;

    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q          <= '0;
      md_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      vld_q          <= vld_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // NOTE: tag/ready payload is not reset; vld alone qualifies every entry.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    rdy_q <= rdy_d;
  end

  assign fwd_sel_a    = rst ? '0 : sel_a;
  assign fwd_sel_b    = rst ? '0 : sel_b;
  assign stall        = stall_int;
  assign md_busy      = ~rst & (md_cnt_q != '0);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random
// traffic against a history-based model (writer age = cycles since issue).
module tb_hazard_scoreboard;
  localparam int RW     = 5;
  localparam int STAGES = 3;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 6;
  localparam int SW     = $clog2(STAGES + 1);
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid, id_rs_used, id_rt_used, id_wr_en;
  logic             id_md_start, id_hilo_rd, flush;
  logic [RW-1:0]    id_rs, id_rt, id_rd;
  logic [SW-1:0]    id_ready_stg;
  logic [SW-1:0]    fwd_sel_a, fwd_sel_b;
  logic             stall, md_busy;
  logic [CNT_W-1:0] stall_cycles;

  hazard_scoreboard #(.RW(RW), .STAGES(STAGES), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_ready_stg(id_ready_stg), .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd),
    .flush(flush), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: list of accepted GPR writers with their issue cycle.
  typedef struct { int cyc; int rd; int rdy; } wr_t;
  wr_t hist[$];
  int  cyc         = 0;
  int  md_issue    = -1000;
  int  stall_cnt_m = 0;

  function automatic void op_eval(input bit use_it, input int r, output int sel, output bit req);
    sel = 0;
    req = 0;
    if (!(id_valid && use_it && r != 0)) return;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      int age;
      age = cyc - hist[i].cyc;
      if (age >= 1 && age <= STAGES && hist[i].rd == r) begin
        if (age >= hist[i].rdy) sel = age;
        else                    req = 1;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    hist.delete();
    md_issue    = -1000;
    stall_cnt_m = 0;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit we, input int rd, input int rdy, input bit md,
                       input bit hilo, input bit fl);
    id_valid     = v;
    id_rs        = RW'(rs);
    id_rs_used   = rsu;
    id_rt        = RW'(rt);
    id_rt_used   = rtu;
    id_wr_en     = we;
    id_rd        = RW'(rd);
    id_ready_stg = SW'(rdy);
    id_md_start  = md;
    id_hilo_rd   = hilo;
    flush        = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // Compare all outputs against the model, then clock one cycle and update it.
  task automatic tick(input string tag);
    int ea, eb;
    bit ra, rb, busy, haz, est, acc;
    #2;
    op_eval(id_rs_used, int'(id_rs), ea, ra);
    op_eval(id_rt_used, int'(id_rt), eb, rb);
    busy = (cyc - md_issue >= 1) && (cyc - md_issue <= MD_LAT);
    haz  = id_valid && (id_hilo_rd || id_md_start) && busy;
    est  = !flush && (ra || rb || haz);
    acc  = id_valid && !est && !flush;
    check({tag, ".fwd_a"}, 32'(fwd_sel_a), ea);
    check({tag, ".fwd_b"}, 32'(fwd_sel_b), eb);
    check({tag, ".stall"}, 32'(stall), 32'(est));
    check({tag, ".md_busy"}, 32'(md_busy), 32'(busy));
    check({tag, ".stall_cyc"}, 32'(stall_cycles), stall_cnt_m);
    @(posedge clk);
    if (acc && id_wr_en && id_rd != 0)
      hist.push_back('{cyc: cyc, rd: int'(id_rd), rdy: int'(id_ready_stg)});
    if (acc && id_md_start) md_issue = cyc;
    if (est && stall_cnt_m < CMAX) stall_cnt_m++;
    while (hist.size() > 0 && (cyc + 1 - hist[0].cyc) > STAGES) void'(hist.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    nop();
    rst = 1'b1;
    #1;
    check("rst.stall", 32'(stall), 0);
    check("rst.fwd_a", 32'(fwd_sel_a), 0);
    check("rst.md_busy", 32'(md_busy), 0);
    check("rst.stall_cyc", 32'(stall_cycles), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    nop();
    @(negedge clk);
    do_reset();

    // 1: ALU chain, forward from EX then MEM
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0); tick("t1_add");
    drive(1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t1_fwd1", 32'(fwd_sel_a), 1); check("t1_nostall", 32'(stall), 0);
    tick("t1_rd1");
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0); tick("t1_add2");
    nop(); tick("t1_nop");
    drive(1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t1_fwd2", 32'(fwd_sel_a), 2);
    tick("t1_rd2");

    // 2: load-use
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0); tick("t2_lw");
    drive(1, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0);
    #1; check("t2_stall", 32'(stall), 1);
    tick("t2_use1");
    #1; check("t2_fwd_b", 32'(fwd_sel_b), 2); check("t2_nostall", 32'(stall), 0);
    tick("t2_use2");
    nop();
    #1; check("t2_cnt", 32'(stall_cycles), 1);
    tick("t2_nop");

    // 3: youngest wins, no fall back to an older ready entry
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); tick("t3_w_old");
    nop(); tick("t3_nop");
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); tick("t3_w_new");
    drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t3_fwd1", 32'(fwd_sel_a), 1);
    tick("t3_rd");
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0); tick("t3b_w_old");
    nop(); tick("t3b_nop");
    drive(1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0); tick("t3b_w_new");
    drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t3b_stall", 32'(stall), 1); check("t3b_fwd0", 32'(fwd_sel_a), 0);
    tick("t3b_rd");

    // 4: $0 and unused operands
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0); tick("t4_w0");
    drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t4_r0_fwd", 32'(fwd_sel_a), 0); check("t4_r0_stall", 32'(stall), 0);
    tick("t4_r0");
    drive(1, 0, 0, 0, 0, 1, 12, 2, 0, 0, 0); tick("t4_w12");
    drive(1, 0, 0, 12, 0, 0, 0, 1, 0, 0, 0);
    #1; check("t4_unused_fwd", 32'(fwd_sel_b), 0); check("t4_unused_stall", 32'(stall), 0);
    tick("t4_unused");

    // 5: mult/div busy window and flush override
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick("t5_mult");
    drive(1, 0, 0, 0, 0, 1, 10, 1, 0, 1, 0);
    for (int i = 0; i < MD_LAT; i++) begin
      #1; check("t5_hilo_stall", 32'(stall), 1);
      tick("t5_mfhi");
    end
    #1; check("t5_accept", 32'(stall), 0); check("t5_idle", 32'(md_busy), 0);
    tick("t5_mfhi_go");
    nop();
    #1; check("t5_cnt", 32'(stall_cycles), MD_LAT);
    tick("t5_nop");
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick("t5_mult2");
    drive(1, 0, 0, 0, 0, 1, 10, 1, 0, 1, 0); tick("t5_mfhi2");
    drive(1, 0, 0, 0, 0, 1, 10, 1, 0, 1, 1);
    #1; check("t5_flush", 32'(stall), 0);
    tick("t5_flushed");

    // 6: asynchronous reset mid-run
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick("t6_mult");
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0); tick("t6_w7");
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0); tick("t6_w6");
    drive(1, 7, 1, 6, 1, 0, 0, 1, 0, 1, 0);
    #1; check("t6_pre_busy", 32'(md_busy), 1); check("t6_pre_fa", 32'(fwd_sel_a), 2);
    check("t6_pre_fb", 32'(fwd_sel_b), 1); check("t6_pre_stall", 32'(stall), 1);
    rst = 1'b1;
    #1; check("t6_busy", 32'(md_busy), 0); check("t6_stall", 32'(stall), 0);
    check("t6_fa", 32'(fwd_sel_a), 0); check("t6_fb", 32'(fwd_sel_b), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1; check("t6_post_fa", 32'(fwd_sel_a), 0);
    tick("t6_post");

    // Random traffic on a small register set to force frequent matches.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
